// File: rtl/phase_to_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : phase_to_clk_gen
// Description : Phase source (DC value or two-point piecewise-linear ramp)
//               driving a numerically controlled oscillator. The NCO emits a
//               square clock whose phase offset follows the selected source.
//               Phase is a signed fraction of one output cycle
//               (2^PH_W units = one cycle). Requires ACC_W > PH_W, T1 > T0.
// Ports       : clk       - system clock, rising edge
//               rst       - asynchronous active-high reset
//               sel_pwl   - 1 = ramp source, 0 = dc_value
//               dc_value  - signed DC phase
//               phase_out - registered selected phase (signed)
//               clk_out   - registered generated clock
// Revision    : 1.0 - initial release
// ============================================================================
module phase_to_clk_gen #(
    parameter int              ACC_W = 24,
    parameter int              PH_W  = 16,
    parameter logic [ACC_W-1:0] FCW  = 24'h180000,
    parameter int              T0    = 100,
    parameter int              T1    = 1300,
    parameter int              V0    = -13107,
    parameter int              V1    = 13107
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel_pwl,
    input  logic signed [PH_W-1:0] dc_value,
    output logic signed [PH_W-1:0] phase_out,
    output logic                   clk_out
);

    // Ramp slope split into integer quotient and remainder at elaboration.
    // SystemVerilog division truncates toward zero, so the quotient is pulled
    // down by one for a negative, inexact dV to obtain a true floor.
    localparam int TW   = $clog2(T1 + 1);
    localparam int EW   = TW + 1;
    localparam int DV   = V1 - V0;
    localparam int DT   = T1 - T0;
    localparam int Q_TR = DV / DT;
    localparam int Q    = ((DV % DT) != 0 && DV < 0) ? Q_TR - 1 : Q_TR;
    localparam int R    = DV - Q * DT;

    localparam logic [TW-1:0]   C_T0   = TW'(T0);
    localparam logic [TW-1:0]   C_T1   = TW'(T1);
    localparam logic [PH_W-1:0] C_V0   = PH_W'(V0);
    localparam logic [PH_W-1:0] C_V1   = PH_W'(V1);
    // Ramp arithmetic runs modulo 2^PH_W; every true intermediate value lies
    // between V0 and V1, so the wrapped sum is always the exact result.
    localparam logic [PH_W-1:0] C_Q    = PH_W'(Q);
    localparam logic [EW-1:0]   C_R    = EW'(R);
    localparam logic [EW-1:0]   C_DT   = EW'(DT);
    localparam logic [ACC_W-1:0] C_HALF = {1'b1, {(ACC_W-1){1'b0}}};

    logic [TW-1:0]          r_tcnt;
    logic [EW-1:0]          r_err;
    logic signed [PH_W-1:0] r_pwl;
    logic [ACC_W-1:0]       r_acc;

    logic [TW-1:0]          w_tcnt_nxt;
    logic [EW-1:0]          w_err_sum;
    logic [EW-1:0]          w_err_nxt;
    logic signed [PH_W-1:0] w_pwl_nxt;
    logic signed [PH_W-1:0] w_ph;
    logic [ACC_W-1:0]       w_p;

    assign w_tcnt_nxt = (r_tcnt == C_T1) ? r_tcnt : r_tcnt + TW'(1);
    assign w_err_sum  = r_err + C_R;

    // The ramp register always holds f(r_tcnt); this computes f(w_tcnt_nxt).
    always_comb begin
        w_pwl_nxt = r_pwl;
        w_err_nxt = r_err;
        if (w_tcnt_nxt <= C_T0) begin
            w_pwl_nxt = C_V0;
            w_err_nxt = '0;
        end else if (w_tcnt_nxt >= C_T1) begin
            // Land exactly on V1; no accumulated rounding can overshoot.
            w_pwl_nxt = C_V1;
            w_err_nxt = '0;
        end else if (w_err_sum >= C_DT) begin
            w_pwl_nxt = r_pwl + C_Q + PH_W'(1);
            w_err_nxt = w_err_sum - C_DT;
        end else begin
            w_pwl_nxt = r_pwl + C_Q;
            w_err_nxt = w_err_sum;
        end
    end

    assign w_ph = sel_pwl ? r_pwl : dc_value;

    // Phase added at the accumulator MSB position: the wrapped sum's top
    // PH_W bits equal acc_top + phase_out modulo one cycle. The clock is high
    // for the first half cycle, i.e. while the sum is below one half.
    assign w_p = r_acc + {phase_out, {(ACC_W-PH_W){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt    <= '0;
            r_err     <= '0;
            r_pwl     <= C_V0;
            r_acc     <= '0;
            phase_out <= '0;
            clk_out   <= 1'b0;
        end else begin
            r_tcnt    <= w_tcnt_nxt;
            r_err     <= w_err_nxt;
            r_pwl     <= w_pwl_nxt;
            r_acc     <= r_acc + FCW;
            phase_out <= w_ph;
            clk_out   <= (w_p < C_HALF);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_to_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_to_clk_gen
// Description : Self-checking bench for phase_to_clk_gen. Three instances:
//               default ramp with random source selection, a short negative
//               ramp, and a single-step (dT=1) jump.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_to_clk_gen;

    localparam logic [23:0] C_FCW = 24'h180000;

    logic               clk;
    logic               rst;
    logic               sel_pwl;
    logic signed [15:0] dc_value;
    logic               sel_one;
    logic signed [15:0] dc_zero;
    logic signed [15:0] ph_m, ph_n, ph_j;
    logic               ck_m, ck_n, ck_j;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int k      = 0;

    // Expected phase_out currently held by each instance
    logic [15:0] e_m, e_n, e_j;

    logic last_clk;
    int   last_rise;
    logic chk_gap;

    phase_to_clk_gen u_main (
        .clk(clk), .rst(rst), .sel_pwl(sel_pwl), .dc_value(dc_value),
        .phase_out(ph_m), .clk_out(ck_m)
    );

    phase_to_clk_gen #(.T0(0), .T1(7), .V0(1000), .V1(-1000)) u_neg (
        .clk(clk), .rst(rst), .sel_pwl(sel_one), .dc_value(dc_zero),
        .phase_out(ph_n), .clk_out(ck_n)
    );

    phase_to_clk_gen #(.T0(3), .T1(4), .V0(-100), .V1(200)) u_jump (
        .clk(clk), .rst(rst), .sel_pwl(sel_one), .dc_value(dc_zero),
        .phase_out(ph_j), .clk_out(ck_j)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floor division for positive divisor
    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Piecewise-linear source value at time t
    function automatic logic [15:0] pwl(input int t, input int t0, input int t1,
                                        input int v0, input int v1);
        int v;
        if (t <= t0)      v = v0;
        else if (t >= t1) v = v1;
        else              v = v0 + fdiv((v1 - v0) * (t - t0), t1 - t0);
        return 16'(v);
    endfunction

    // Clock level at edge kk from NCO phase after kk-1 edges plus held phase
    function automatic logic model_clk(input int kk, input logic [15:0] ph);
        logic [23:0] acc;
        logic [15:0] p;
        acc = 24'(longint'(kk - 1) * longint'(C_FCW));
        p   = acc[23:8] + ph;
        return ~p[15];
    endfunction

    function automatic int tsat(input int t, input int t1);
        return (t > t1) ? t1 : t;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, k);
        end
    endtask

    // One clock edge: advance the model using the inputs held before the edge
    task automatic step();
        logic c_m, c_n, c_j;
        @(posedge clk);
        #1;
        k++;
        c_m = model_clk(k, e_m);
        c_n = model_clk(k, e_n);
        c_j = model_clk(k, e_j);
        e_m = sel_pwl ? pwl(tsat(k - 1, 1300), 100, 1300, -13107, 13107) : dc_value;
        e_n = pwl(tsat(k - 1, 7), 0, 7, 1000, -1000);
        e_j = pwl(tsat(k - 1, 4), 3, 4, -100, 200);
        check("main_phase", ph_m, e_m);
        check("main_clk", 16'(ck_m), 16'(c_m));
        check("neg_phase", ph_n, e_n);
        check("neg_clk", 16'(ck_n), 16'(c_n));
        check("jump_phase", ph_j, e_j);
        check("jump_clk", 16'(ck_j), 16'(c_j));
        if (chk_gap && ck_m && !last_clk) begin
            if (last_rise >= 0)
                check("rise_gap", 16'((k - last_rise == 10) || (k - last_rise == 11)), 16'd1);
            last_rise = k;
        end
        last_clk = ck_m;
    endtask

    task automatic restart_model();
        k = 0;
        e_m = '0; e_n = '0; e_j = '0;
        last_clk = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        sel_pwl   = 1'b0;
        dc_value  = '0;
        sel_one   = 1'b1;
        dc_zero   = '0;
        chk_gap   = 1'b0;
        last_rise = -1;
        restart_model();

        // Reset state
        #12;
        check("rst_phase", ph_m, 16'd0);
        check("rst_clk", 16'(ck_m), 16'd0);
        check("rst_neg_phase", ph_n, 16'd0);
        #10 rst = 1'b0;

        // DC zero: plain 10/11-cycle output clock, phase_out stays 0
        chk_gap = 1'b1;
        repeat (60) step();
        chk_gap = 1'b0;

        // Random source selection and DC values up to tcnt = 500
        while (k < 500) begin
            sel_pwl  = ($urandom_range(0, 3) != 0);
            dc_value = 16'($urandom);
            step();
        end

        // Asynchronous reset mid-ramp: outputs clear without a clock edge
        #3 rst = 1'b1;
        #1;
        check("async_rst_phase", ph_m, 16'd0);
        check("async_rst_clk", 16'(ck_m), 16'd0);
        check("async_rst_neg", ph_n, 16'd0);
        repeat (3) @(posedge clk);
        #4 rst = 1'b0;
        restart_model();

        // Ramp restarts from V0; random toggling through saturation
        while (k < 1400) begin
            sel_pwl  = ($urandom_range(0, 2) != 0);
            dc_value = 16'($urandom);
            if (k == 700 || k >= 1350) sel_pwl = 1'b1;
            step();
            if (k == 701) check("ramp_mid_zero", ph_m, 16'd0);
            if (k == 1400) check("ramp_final", ph_m, 16'(13107));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phase_to_clk_gen.md
# phase_to_clk_gen

Digital stimulus block: a phase source (DC or two-point piecewise-linear ramp) drives a numerically controlled oscillator that emits a square clock whose phase offset follows the source. It generates reference and feedback clocks with a controlled, slowly varying phase difference for TDC and PLL characterisation benches. One instance per generated clock; phase is a signed fraction of one output cycle.

## Interface
- ACC_W, 24: NCO accumulator width (unsigned modulo 2^ACC_W).
- PH_W, 16: phase width; 2^PH_W units = one output cycle.
- FCW, 24'h180000: frequency control word, added each clk. At 1 GHz clk this gives 93.75 MHz output.
- T0, 100: ramp start time in clk cycles.
- T1, 1300: ramp end time; must be > T0.
- V0, -13107: signed phase before/at T0 (-0.2 cycle).
- V1, 13107: signed phase at/after T1 (+0.2 cycle).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel_pwl  input  1  1 = PWL source, 0 = DC source.
- dc_value  input  PH_W signed  phase used when sel_pwl=0.
- phase_out  output  PH_W signed  current phase source value, registered.
- clk_out  output  1  generated clock, registered.

## Operation
- Time counter tcnt: 0 at reset, +1 per clk, saturates at T1. Width must hold T1.
- PWL value f(t), all widths signed:
  - t <= T0: f = V0.
  - T0 < t < T1: f = V0 + floor((V1-V0)*(t-T0)/(T1-T0)).
  - t >= T1: f = V1.
- No runtime divider. Q = floor(dV/dT) and R = dV - Q*dT are elaboration-time constants, where dV = V1-V0 and dT = T1-T0.
  - Each ramp cycle: value += Q; err += R.
  - If err >= dT: value += 1 and err -= dT.
  - The result must match the floor formula exactly, including negative dV.
- Selected phase: ph = sel_pwl ? pwl_value : dc_value. phase_out <= ph.
- NCO: acc <= acc + FCW (mod 2^ACC_W).
- Output phase p = acc[ACC_W-1 -: PH_W] + phase_out (mod 2^PH_W).
- clk_out <= ~p[PH_W-1], i.e. high for p in [0, 0.5 cycle). Positive phase advances the clock's rising edge.
- sel_pwl and dc_value may change any cycle and take effect on phase_out at the next edge. The PWL engine keeps running regardless of sel_pwl.

## Timing
- Reset (asynchronous, immediate): tcnt=0, acc=0, err=0, pwl_value=V0, phase_out=0, clk_out=0.
- Edge k after reset release (k=1,2,…) uses values held after edge k-1:
  - tcnt = k (saturating at T1).
  - phase_out = ph computed from tcnt = k-1.
  - clk_out = ~p[PH_W-1] using acc and phase_out as held before edge k.
- Latency: source→phase_out is 1 clk; phase_out→clk_out is 1 clk.
- Boundary conditions:
  - Ramp is exactly V1 from tcnt = T1 onward, with no overshoot.
  - acc wraps silently.
  - p wraps modulo one cycle, so phase ±0.5 cycles aliases correctly.
  - Reset asserted mid-ramp restarts from t=0.
  - dT=1 gives a one-step jump.
- Output period = 2^ACC_W / FCW clk cycles. Duty cycle is 50% ± 1 clk.

## Test plan
- Reset, sel_pwl=0, dc_value=0, FCW default: clk_out has period 10.667 clk (rising-edge spacing alternates 10/11 clk), ~50% duty; phase_out=0.
- Two instances, one dc_value=0 and one dc_value=16384 (+0.25 cycle): second clk_out leads first by ≈2.67 clk at every rising edge.
- sel_pwl=1, defaults: phase_out = -13107 for tcnt ≤100; 0 at tcnt=700; 13107 for tcnt ≥1300. Matches the floor formula every cycle against a reference model.
- Negative ramp (V0=1000, V1=-1000, T0=0, T1=7): each value equals floor(-2000*t/7) + 1000 exactly; final value -1000.
- Assert rst at tcnt=500 for 3 clk, asynchronous to the clk edge: outputs zero immediately; after release the ramp restarts at V0 and reaches 0 at tcnt=700.
- Toggle sel_pwl mid-ramp: phase_out switches source on the next edge. The PWL trajectory is unaffected when switched back.
